// File: rtl/bus_interface_unit.sv
// bus_interface_unit
// Phase generator and external bus interface for the 6502 core.
// Produces the one-cycle phase_1/phase_2 strobes that pace the datapath,
// captures the internal ADL/ADH buses into the external address register,
// and runs one external read or write per machine cycle with a wait-state
// handshake. Read data lands in the input data latch (DL), which can drive
// the internal data bus or either address bus; write data comes from DOR.
//
// Ports:
//   sys_clock, reset         clock, synchronous active-high reset
//   phase_1, phase_2, stall  phase strobes and wait-state indicator
//   adl_abl, adh_abh, rw     address register load enables, read/write
//   db_dor                   load DOR from data_bus
//   dl_db, dl_adl, dl_adh    DL bus driver enables
//   address_l/_h, data_bus   internal tri-state buses
//   mem_*                    external memory request/response
module bus_interface_unit #(
  parameter int unsigned PHASE_CYCLES    = 2,
  parameter logic [15:0] ABUS_RESET_ADDR = 16'hFFFC
) (
  input  logic        sys_clock,
  input  logic        reset,
  output logic        phase_1,
  output logic        phase_2,
  output logic        stall,
  input  logic        adl_abl,
  input  logic        adh_abh,
  input  logic        rw,
  input  logic        db_dor,
  input  logic        dl_db,
  input  logic        dl_adl,
  input  logic        dl_adh,
  inout  wire  [7:0]  address_l,
  inout  wire  [7:0]  address_h,
  inout  wire  [7:0]  data_bus,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    ST_PHI1 = 2'd0,
    ST_PHI2 = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(PHASE_CYCLES - 1);

  state_t     state_r;
  state_t     state_s;
  logic [7:0] cnt_r;
  logic [7:0] abl_r;
  logic [7:0] abh_r;
  logic [7:0] dl_r;
  logic [7:0] dor_r;
  logic       rw_q_r;
  logic       cnt_last_s;
  logic       p1_cycle_s;
  logic       complete_s;

  assign cnt_last_s = (cnt_r == CNT_LAST);
  // Ungated phase_1 decode; the address capture edge is the end of this cycle.
  assign p1_cycle_s = (state_r == ST_PHI1) && (cnt_r == 8'd0);
  // mem_ready only matters at the last PHI2 cycle or while waiting.
  assign complete_s = mem_ready &&
                      (((state_r == ST_PHI2) && cnt_last_s) || (state_r == ST_WAIT));

  // State and phase counter register; counter clears on every state change.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_r <= ST_PHI1;
      cnt_r   <= 8'd0;
    end else if (state_s != state_r) begin
      state_r <= state_s;
      cnt_r   <= 8'd0;
    end else if (state_r == ST_WAIT) begin
      cnt_r   <= cnt_r;
    end else begin
      cnt_r   <= cnt_r + 8'd1;
    end
  end

  // Next-state decode for the phase sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_PHI1: begin
        if (cnt_last_s) state_s = ST_PHI2;
        else            state_s = ST_PHI1;
      end
      ST_PHI2: begin
        if (cnt_last_s) state_s = mem_ready ? ST_PHI1 : ST_WAIT;
        else            state_s = ST_PHI2;
      end
      ST_WAIT: begin
        if (mem_ready) state_s = ST_PHI1;
        else           state_s = ST_WAIT;
      end
      default: state_s = ST_PHI1;
    endcase
  end

  // Output decode; strobes are suppressed while reset is held.
  always_comb begin
    phase_1 = 1'b0;
    phase_2 = 1'b0;
    mem_req = 1'b0;
    stall   = 1'b0;
    if (!reset) begin
      phase_1 = p1_cycle_s;
      phase_2 = (state_r == ST_PHI2) && (cnt_r == 8'd0);
    end else begin
      phase_1 = 1'b0;
      phase_2 = 1'b0;
    end
    mem_req = (state_r == ST_PHI2) || (state_r == ST_WAIT);
    stall   = (state_r == ST_WAIT);
    mem_we  = mem_req && !rw_q_r;
  end

  // Address register and rw capture at the end of the phase_1 cycle.
  // When DL drives an address bus the loaded value is taken from DL directly.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      abl_r  <= ABUS_RESET_ADDR[7:0];
      abh_r  <= ABUS_RESET_ADDR[15:8];
      rw_q_r <= 1'b1;
    end else if (p1_cycle_s) begin
      if (adl_abl) abl_r <= dl_adl ? dl_r : address_l;
      else         abl_r <= abl_r;
      if (adh_abh) abh_r <= dl_adh ? dl_r : address_h;
      else         abh_r <= abh_r;
      rw_q_r <= rw;
    end else begin
      abl_r  <= abl_r;
      abh_r  <= abh_r;
      rw_q_r <= rw_q_r;
    end
  end

  // Input data latch: captures read data on access completion.
  always_ff @(posedge sys_clock) begin
    if (reset)                    dl_r <= 8'h00;
    else if (complete_s && rw_q_r) dl_r <= mem_rdata;
    else                          dl_r <= dl_r;
  end

  // Data output register: loads from the internal data bus on request.
  always_ff @(posedge sys_clock) begin
    if (reset)       dor_r <= 8'h00;
    else if (db_dor) dor_r <= data_bus;
    else             dor_r <= dor_r;
  end

  assign mem_addr  = {abh_r, abl_r};
  assign mem_wdata = dor_r;

  assign data_bus  = dl_db  ? dl_r : 8'hzz;
  assign address_l = dl_adl ? dl_r : 8'hzz;
  assign address_h = dl_adh ? dl_r : 8'hzz;

endmodule

// File: tb/tb_bus_interface_unit.sv
// Directed self-checking bench for bus_interface_unit (PHASE_CYCLES=2),
// with a second PHASE_CYCLES=1 instance checked during the idle phase.
module tb_bus_interface_unit;

  logic        sys_clock;
  logic        reset;
  logic        adl_abl, adh_abh, rw, db_dor, dl_db, dl_adl, dl_adh;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  wire         phase_1, phase_2, stall, mem_req, mem_we;
  wire  [15:0] mem_addr;
  wire  [7:0]  mem_wdata;
  wire  [7:0]  address_l, address_h, data_bus;

  logic        al_en, ah_en, db_en;
  logic [7:0]  al_val, ah_val, db_val;

  assign address_l = al_en ? al_val : 8'hzz;
  assign address_h = ah_en ? ah_val : 8'hzz;
  assign data_bus  = db_en ? db_val : 8'hzz;

  wire         b_p1, b_p2, b_stall, b_req, b_we;
  wire  [15:0] b_addr;
  wire  [7:0]  b_wdata;
  wire  [7:0]  b_al, b_ah, b_db;
  assign b_al = 8'hzz;
  assign b_ah = 8'hzz;
  assign b_db = 8'hzz;

  int n_cmp = 0;
  int n_err = 0;

  bus_interface_unit #(.PHASE_CYCLES(2), .ABUS_RESET_ADDR(16'hFFFC)) u_dut (
    .sys_clock(sys_clock), .reset(reset),
    .phase_1(phase_1), .phase_2(phase_2), .stall(stall),
    .adl_abl(adl_abl), .adh_abh(adh_abh), .rw(rw), .db_dor(db_dor),
    .dl_db(dl_db), .dl_adl(dl_adl), .dl_adh(dl_adh),
    .address_l(address_l), .address_h(address_h), .data_bus(data_bus),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready)
  );

  bus_interface_unit #(.PHASE_CYCLES(1), .ABUS_RESET_ADDR(16'hFFFC)) u_dut1 (
    .sys_clock(sys_clock), .reset(reset),
    .phase_1(b_p1), .phase_2(b_p2), .stall(b_stall),
    .adl_abl(1'b0), .adh_abh(1'b0), .rw(1'b1), .db_dor(1'b0),
    .dl_db(1'b0), .dl_adl(1'b0), .dl_adh(1'b0),
    .address_l(b_al), .address_h(b_ah), .data_bus(b_db),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(8'h00),
    .mem_req(b_req), .mem_we(b_we), .mem_ready(mem_ready)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clock);
    #1;
  endtask

  task automatic check_dl(input string tag, input logic [7:0] exp);
    dl_db = 1'b1;
    #1;
    check_value(tag, {8'h00, data_bus}, {8'h00, exp});
    dl_db = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    adl_abl = 1'b0; adh_abh = 1'b0; rw = 1'b1; db_dor = 1'b0;
    dl_db = 1'b0; dl_adl = 1'b0; dl_adh = 1'b0;
    mem_rdata = 8'h00; mem_ready = 1'b1;
    al_en = 1'b0; ah_en = 1'b0; db_en = 1'b0;
    al_val = 8'h00; ah_val = 8'h00; db_val = 8'h00;

    // Reset state
    repeat (3) tick;
    check_value("rst_phase_1", {15'd0, phase_1}, 16'd0);
    check_value("rst_phase_2", {15'd0, phase_2}, 16'd0);
    check_value("rst_mem_req", {15'd0, mem_req}, 16'd0);
    check_value("rst_mem_we",  {15'd0, mem_we},  16'd0);
    check_value("rst_stall",   {15'd0, stall},   16'd0);
    check_value("rst_addr",    mem_addr, 16'hFFFC);
    check_value("rst_wdata",   {8'h00, mem_wdata}, 16'h0000);

    // Idle reads with mem_ready tied high: 4-cycle machine cycle
    reset = 1'b0;
    #1;
    for (int c = 0; c < 12; c++) begin
      check_value("idle_p1",   {15'd0, phase_1}, {15'd0, (c % 4) == 0});
      check_value("idle_p2",   {15'd0, phase_2}, {15'd0, (c % 4) == 2});
      check_value("idle_req",  {15'd0, mem_req}, {15'd0, (c % 4) >= 2});
      check_value("idle_addr", mem_addr, 16'hFFFC);
      check_value("pc1_p1",    {15'd0, b_p1},  {15'd0, (c % 2) == 0});
      check_value("pc1_p2",    {15'd0, b_p2},  {15'd0, (c % 2) == 1});
      check_value("pc1_req",   {15'd0, b_req}, {15'd0, (c % 2) == 1});
      if (c == 0) begin
        check_value("pc1_addr",  b_addr, 16'hFFFC);
        check_value("pc1_stall", {15'd0, b_stall}, 16'd0);
        check_value("pc1_we",    {15'd0, b_we}, 16'd0);
        check_value("pc1_wdata", {8'h00, b_wdata}, 16'h0000);
      end
      tick;
    end

    // Address load and read (cycle 0 = phase_1)
    check_value("ld_p1", {15'd0, phase_1}, 16'd1);
    al_en = 1'b1; al_val = 8'h34; ah_en = 1'b1; ah_val = 8'h12;
    adl_abl = 1'b1; adh_abh = 1'b1; mem_rdata = 8'hA9;
    tick;
    al_en = 1'b0; ah_en = 1'b0; adl_abl = 1'b0; adh_abh = 1'b0;
    #1;
    check_value("ld_addr", mem_addr, 16'h1234);
    tick;
    check_value("ld_p2",  {15'd0, phase_2}, 16'd1);
    check_value("ld_req", {15'd0, mem_req}, 16'd1);
    check_value("ld_we",  {15'd0, mem_we},  16'd0);
    tick;
    tick;
    check_value("ld_next_p1", {15'd0, phase_1}, 16'd1);
    check_dl("ld_dl_db", 8'hA9);

    // Write cycle
    db_en = 1'b1; db_val = 8'h5A; db_dor = 1'b1; rw = 1'b0;
    tick;
    db_en = 1'b0; db_dor = 1'b0; rw = 1'b1;
    #1;
    check_value("wr_wdata",  {8'h00, mem_wdata}, 16'h005A);
    check_value("wr_we_phi1", {15'd0, mem_we}, 16'd0);
    tick;
    mem_rdata = 8'h33;
    check_value("wr_we_phi2a", {15'd0, mem_we}, 16'd1);
    tick;
    check_value("wr_we_phi2b", {15'd0, mem_we}, 16'd1);
    check_value("wr_addr",     mem_addr, 16'h1234);
    tick;
    check_value("wr_next_p1", {15'd0, phase_1}, 16'd1);
    check_value("wr_we_after", {15'd0, mem_we}, 16'd0);
    check_dl("wr_dl_kept", 8'hA9);

    // Wait states: three WAIT cycles
    mem_rdata = 8'hC3;
    tick;
    tick;
    mem_ready = 1'b0;
    tick;
    mem_rdata = 8'h55;
    #1;
    check_value("ws_no_stall_phi2", {15'd0, stall}, 16'd0);
    tick;
    mem_rdata = 8'h11;
    #1;
    check_value("ws1_stall", {15'd0, stall},   16'd1);
    check_value("ws1_req",   {15'd0, mem_req}, 16'd1);
    check_value("ws1_p1",    {15'd0, phase_1}, 16'd0);
    check_value("ws1_p2",    {15'd0, phase_2}, 16'd0);
    check_value("ws1_addr",  mem_addr, 16'h1234);
    tick;
    check_value("ws2_stall", {15'd0, stall},   16'd1);
    check_value("ws2_p1",    {15'd0, phase_1}, 16'd0);
    check_value("ws2_addr",  mem_addr, 16'h1234);
    tick;
    check_value("ws3_stall", {15'd0, stall},   16'd1);
    check_value("ws3_req",   {15'd0, mem_req}, 16'd1);
    mem_ready = 1'b1; mem_rdata = 8'hC3;
    tick;
    check_value("ws_end_p1",    {15'd0, phase_1}, 16'd1);
    check_value("ws_end_stall", {15'd0, stall},   16'd0);
    check_value("ws_end_req",   {15'd0, mem_req}, 16'd0);
    check_dl("ws_dl", 8'hC3);

    // Loopback: read 7F into DL, then ABL <= DL
    mem_rdata = 8'h7F;
    repeat (4) tick;
    check_value("lb_p1", {15'd0, phase_1}, 16'd1);
    dl_adl = 1'b1; adl_abl = 1'b1;
    #1;
    check_value("lb_bus", {8'h00, address_l}, 16'h007F);
    tick;
    dl_adl = 1'b0; adl_abl = 1'b0;
    #1;
    check_value("lb_addr", mem_addr, 16'h127F);

    // Early mem_ready in first PHI2 cycle is ignored; stall follows
    tick;
    mem_ready = 1'b1; mem_rdata = 8'hEE;
    tick;
    mem_ready = 1'b0;
    tick;
    check_value("early_rdy_stall", {15'd0, stall}, 16'd1);
    check_dl("early_rdy_dl", 8'h7F);

    // Reset during WAIT with a completing response present
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 8'hEE;
    #1;
    check_value("rw_p1_forced", {15'd0, phase_1}, 16'd0);
    tick;
    check_value("rw_req",   {15'd0, mem_req}, 16'd0);
    check_value("rw_addr",  mem_addr, 16'hFFFC);
    check_value("rw_stall", {15'd0, stall}, 16'd0);
    reset = 1'b0;
    #1;
    check_value("rw_first_p1", {15'd0, phase_1}, 16'd1);
    check_dl("rw_dl", 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
